// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational instruction ROM between fetch and data.
// Data wins by default; a bounded wait counter hands priority to fetch.
module rom_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_REQ,
    input  logic [ADDR_WIDTH-1:0] I_ADDR,
    output logic                  I_GNT,
    output logic                  I_VALID,
    output logic [DATA_WIDTH-1:0] I_DATA,
    input  logic                  D_REQ,
    input  logic [ADDR_WIDTH-1:0] D_ADDR,
    output logic                  D_GNT,
    output logic                  D_VALID,
    output logic [DATA_WIDTH-1:0] D_DATA,
    output logic [ADDR_WIDTH-1:0] ROM_ADDRESS,
    input  logic [DATA_WIDTH-1:0] ROM_DATA_OUT
);

    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW:0]   MAXW = (WW + 1)'(MAX_WAIT);
    localparam logic [WW-1:0] MAXC = WW'(MAX_WAIT);

    typedef enum logic {
        PRIO_D = 1'b0,
        PRIO_I = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WW-1:0]         wcnt_q, wcnt_d;
    logic [WW:0]           wnext;
    logic                  i_gnt, d_gnt;
    logic                  i_valid_q, i_valid_d;
    logic                  d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0] i_data_q, i_data_d;
    logic [DATA_WIDTH-1:0] d_data_q, d_data_d;

    // Grant decision and ROM address steering; nothing granted during reset.
    always_comb begin
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        ROM_ADDRESS = '0;
        if (!RESET) begin
            if (I_REQ && D_REQ) begin
                if (state_q == PRIO_I) i_gnt = 1'b1;
                else                   d_gnt = 1'b1;
            end else begin
                i_gnt = I_REQ;
                d_gnt = D_REQ;
            end
            ROM_ADDRESS = d_gnt ? D_ADDR : I_ADDR;
        end
    end

    // Next priority state and starvation counter for the fetch port.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wnext   = {1'b0, wcnt_q} + 1'b1;
        if (I_REQ && !i_gnt) begin
            if (wnext >= MAXW) begin
                wcnt_d  = MAXC;
                state_d = PRIO_I;
            end else begin
                wcnt_d = wnext[WW-1:0];
            end
        end else begin
            wcnt_d  = '0;
            state_d = PRIO_D;
        end
    end

    // Capture ROM data for the granted port; pulse its valid for one cycle.
    always_comb begin
        i_valid_d = i_gnt;
        d_valid_d = d_gnt;
        i_data_d  = i_gnt ? ROM_DATA_OUT : i_data_q;
        d_data_d  = d_gnt ? ROM_DATA_OUT : d_data_q;
    end

    // State and read-data registers, cleared asynchronously.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= PRIO_D;
            wcnt_q    <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_data_q  <= '0;
            d_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            i_data_q  <= i_data_d;
            d_data_q  <= d_data_d;
        end
    end

    assign I_GNT   = i_gnt;
    assign D_GNT   = d_gnt;
    assign I_VALID = i_valid_q;
    assign D_VALID = d_valid_q;
    assign I_DATA  = i_data_q;
    assign D_DATA  = d_data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed checks of grant rules, read latency and reset.
// ROM model: word 5 holds 0x00500093, every other word is 0xC0DE0000 | addr.
module tb_rom_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        I_REQ, D_REQ;
    logic [9:0]  I_ADDR, D_ADDR;
    logic        I_GNT, D_GNT, I_VALID, D_VALID;
    logic [31:0] I_DATA, D_DATA;
    logic [9:0]  ROM_ADDRESS;
    logic [31:0] ROM_DATA_OUT;

    int checks = 0;
    int fails  = 0;

    rom_arbiter #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .MAX_WAIT(2)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .I_REQ(I_REQ),
        .I_ADDR(I_ADDR),
        .I_GNT(I_GNT),
        .I_VALID(I_VALID),
        .I_DATA(I_DATA),
        .D_REQ(D_REQ),
        .D_ADDR(D_ADDR),
        .D_GNT(D_GNT),
        .D_VALID(D_VALID),
        .D_DATA(D_DATA),
        .ROM_ADDRESS(ROM_ADDRESS),
        .ROM_DATA_OUT(ROM_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        ROM_DATA_OUT = 32'hC0DE0000 | {22'd0, ROM_ADDRESS};
        if (ROM_ADDRESS == 10'd5) ROM_DATA_OUT = 32'h00500093;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // grant order under contention: 1 = data, 0 = fetch
    logic [5:0]  exp_d = 6'b011011;
    logic [9:0]  da;
    logic [9:0]  ia;
    logic [31:0] last_i;
    logic [31:0] last_d;

    initial begin
        RESET  = 1'b1;
        I_REQ  = 1'b1;
        D_REQ  = 1'b1;
        I_ADDR = 10'd5;
        D_ADDR = 10'd7;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_i_gnt", I_GNT, 0);
        chk("rst_d_gnt", D_GNT, 0);
        chk("rst_addr", ROM_ADDRESS, 0);
        chk("rst_i_valid", I_VALID, 0);
        chk("rst_d_valid", D_VALID, 0);
        chk("rst_i_data", I_DATA, 0);
        chk("rst_d_data", D_DATA, 0);

        // release reset: contention from PRIO_D, data wins
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rel_d_gnt", D_GNT, 1);
        chk("rel_i_gnt", I_GNT, 0);
        chk("rel_addr", ROM_ADDRESS, 7);
        @(posedge CLK);
        #1;
        chk("rel_d_valid", D_VALID, 1);
        chk("rel_d_data", D_DATA, 32'hC0DE0007);
        chk("rel_i_valid", I_VALID, 0);

        // lone fetch of word 5
        @(negedge CLK);
        D_REQ = 1'b0;
        #1;
        chk("lf_i_gnt", I_GNT, 1);
        chk("lf_d_gnt", D_GNT, 0);
        chk("lf_addr", ROM_ADDRESS, 5);
        @(posedge CLK);
        #1;
        chk("lf_i_valid", I_VALID, 1);
        chk("lf_i_data", I_DATA, 32'h00500093);
        chk("lf_d_valid", D_VALID, 0);
        chk("lf_d_hold", D_DATA, 32'hC0DE0007);

        // idle cycle: no grant, valids drop, data held
        @(negedge CLK);
        I_REQ = 1'b0;
        #1;
        chk("idle_i_gnt", I_GNT, 0);
        chk("idle_d_gnt", D_GNT, 0);
        @(posedge CLK);
        #1;
        chk("idle_i_valid", I_VALID, 0);
        chk("idle_d_valid", D_VALID, 0);
        chk("idle_i_data", I_DATA, 32'h00500093);
        chk("idle_d_data", D_DATA, 32'hC0DE0007);

        // contention for 6 cycles: D, D, I, D, D, I
        da = 10'd0;
        ia = 10'd9;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            I_REQ  = 1'b1;
            D_REQ  = 1'b1;
            I_ADDR = ia;
            D_ADDR = da;
            #1;
            chk($sformatf("ct%0d_d_gnt", c), D_GNT, exp_d[c]);
            chk($sformatf("ct%0d_i_gnt", c), I_GNT, !exp_d[c]);
            @(posedge CLK);
            #1;
            chk($sformatf("ct%0d_d_valid", c), D_VALID, exp_d[c]);
            chk($sformatf("ct%0d_i_valid", c), I_VALID, !exp_d[c]);
            if (exp_d[c]) begin
                chk($sformatf("ct%0d_d_data", c), D_DATA,
                    32'hC0DE0000 | {22'd0, da});
                da = da + 10'd1;
            end else begin
                chk($sformatf("ct%0d_i_data", c), I_DATA,
                    32'hC0DE0000 | {22'd0, ia});
                ia = ia + 10'd1;
            end
        end
        last_i = 32'hC0DE000A;

        // back-to-back data reads 3, 4, 20
        @(negedge CLK);
        I_REQ = 1'b0;
        D_REQ = 1'b1;
        D_ADDR = 10'd3;
        #1;
        chk("bb0_d_gnt", D_GNT, 1);
        @(posedge CLK);
        #1;
        chk("bb0_d_valid", D_VALID, 1);
        chk("bb0_d_data", D_DATA, 32'hC0DE0003);
        @(negedge CLK);
        D_ADDR = 10'd4;
        #1;
        chk("bb1_d_gnt", D_GNT, 1);
        @(posedge CLK);
        #1;
        chk("bb1_d_valid", D_VALID, 1);
        chk("bb1_d_data", D_DATA, 32'hC0DE0004);
        chk("bb1_i_hold", I_DATA, last_i);
        @(negedge CLK);
        D_ADDR = 10'd20;
        #1;
        chk("bb2_d_gnt", D_GNT, 1);
        @(posedge CLK);
        #1;
        chk("bb2_d_valid", D_VALID, 1);
        chk("bb2_d_data", D_DATA, 32'hC0DE0014);
        chk("bb2_i_hold", I_DATA, last_i);
        chk("bb2_i_valid", I_VALID, 0);

        // drive to PRIO_I with two denials, then a lone data request
        @(negedge CLK);
        I_REQ  = 1'b1;
        I_ADDR = 10'd12;
        D_ADDR = 10'd30;
        #1;
        chk("pi0_d_gnt", D_GNT, 1);
        @(negedge CLK);
        D_ADDR = 10'd31;
        #1;
        chk("pi1_d_gnt", D_GNT, 1);
        @(negedge CLK);
        I_REQ  = 1'b0;
        D_ADDR = 10'd32;
        #1;
        chk("pi_lone_d_gnt", D_GNT, 1);
        chk("pi_lone_i_gnt", I_GNT, 0);
        @(posedge CLK);
        #1;
        chk("pi_lone_d_data", D_DATA, 32'hC0DE0020);
        // back in PRIO_D with counter cleared: D, D, then I
        @(negedge CLK);
        I_REQ  = 1'b1;
        D_ADDR = 10'd33;
        #1;
        chk("pd0_d_gnt", D_GNT, 1);
        @(negedge CLK);
        D_ADDR = 10'd34;
        #1;
        chk("pd1_d_gnt", D_GNT, 1);
        @(negedge CLK);
        #1;
        chk("pd2_i_gnt", I_GNT, 1);
        chk("pd2_addr", ROM_ADDRESS, 12);
        @(posedge CLK);
        #1;
        chk("pd2_i_data", I_DATA, 32'hC0DE000C);
        last_d = 32'hC0DE0022;
        chk("pd2_d_hold", D_DATA, last_d);

        // reset lands before the edge that would capture fetch of word 1
        @(negedge CLK);
        D_REQ  = 1'b0;
        I_ADDR = 10'd1;
        #1;
        chk("mr_i_gnt", I_GNT, 1);
        #2;
        RESET = 1'b1;
        #1;
        chk("mr_gnt_off", I_GNT, 0);
        chk("mr_addr", ROM_ADDRESS, 0);
        chk("mr_i_data_clr", I_DATA, 0);
        @(posedge CLK);
        #1;
        chk("mr_i_valid", I_VALID, 0);
        chk("mr_i_data", I_DATA, 0);
        chk("mr_d_data", D_DATA, 0);

        @(negedge CLK);
        I_REQ = 1'b0;
        RESET = 1'b0;
        repeat (2) @(posedge CLK);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
